// File: rtl/alu_muldiv_unit.sv
// -----------------------------------------------------------------------------
// alu_muldiv_unit
//
// Handshaked execution unit for the RISC-V datapath.
//   * RV32I ALU ops (ADD..SLTU) and branch-condition evaluation complete in one
//     registered cycle.
//   * RV32M MUL/MULHU/DIV/DIVU/REM/REMU run iteratively, one shift-add or
//     restoring shift-subtract step per cycle over XLEN cycles.
//
// Build option:
//   ALU_MULDIV_EN  defined   -> iterative multiply/divide datapath and CALC state
//                             are built.
//                  undefined -> no mul/div hardware; ops 10..15 complete in one
//                             cycle with result=0, bcond=0, busy never rises.
//
// Handshake: a request transfers on a rising edge where in_valid && in_ready;
// a result transfers on a rising edge where out_valid && out_ready. Once
// out_valid is high, result/bcond stay stable until that transfer (or a flush
// or reset). in_ready is combinational from state, out_ready and flush; all
// other outputs are registered.
//
// Ports:
//   clk        in   rising-edge clock
//   reset      in   asynchronous active-low reset
//   in_valid   in   request present
//   in_ready   out  unit accepts a request this cycle
//   alu_op     in   [3:0] operation (0 ADD .. 15 REMU)
//   funct3     in   [2:0] branch condition, meaningful only with SUB
//   operand_a  in   [XLEN-1:0] source operand A
//   operand_b  in   [XLEN-1:0] source operand B
//   flush      in   synchronous abort of in-flight or completed result
//   out_valid  out  result available
//   out_ready  in   consumer takes the result this cycle
//   result     out  [XLEN-1:0] registered result
//   bcond      out  registered branch condition
//   busy       out  high while the iterative datapath is working
//   state_dbg  out  [1:0] current FSM state (0 IDLE, 1 CALC, 2 DONE)
// -----------------------------------------------------------------------------
module alu_muldiv_unit #(
    parameter int XLEN    = 32,
    parameter int SHAMT_W = $clog2(XLEN)
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [3:0]      alu_op,
    input  logic [2:0]      funct3,
    input  logic [XLEN-1:0] operand_a,
    input  logic [XLEN-1:0] operand_b,
    input  logic            flush,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] result,
    output logic            bcond,
    output logic            busy,
    output logic [1:0]      state_dbg
);

    localparam logic [3:0] OP_ADD  = 4'd0;
    localparam logic [3:0] OP_SUB  = 4'd1;
    localparam logic [3:0] OP_SLL  = 4'd2;
    localparam logic [3:0] OP_XOR  = 4'd3;
    localparam logic [3:0] OP_OR   = 4'd4;
    localparam logic [3:0] OP_AND  = 4'd5;
    localparam logic [3:0] OP_SRL  = 4'd6;
    localparam logic [3:0] OP_SRA  = 4'd7;
    localparam logic [3:0] OP_SLT  = 4'd8;
    localparam logic [3:0] OP_SLTU = 4'd9;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CALC = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t state;

    logic               accept;
    logic [SHAMT_W-1:0] shamt;
    logic               lt_s;
    logic               lt_u;
    logic               eq;
    logic [XLEN-1:0]    alu_res;
    logic               bcond_c;

    assign in_ready  = !flush && ((state == ST_IDLE) || ((state == ST_DONE) && out_ready));
    assign accept    = in_valid && in_ready;
    assign state_dbg = state;

    assign shamt = operand_b[SHAMT_W-1:0];
    // True signed compare: immune to overflow of the SUB difference.
    assign lt_s  = $signed(operand_a) < $signed(operand_b);
    assign lt_u  = operand_a < operand_b;
    assign eq    = operand_a == operand_b;

    // Single-cycle ALU. Mul/div opcodes fall to the default (0), which is
    // exactly the result required when the iterative datapath is not built.
    always_comb begin
        alu_res = '0;
        case (alu_op)
            OP_ADD:  alu_res = operand_a + operand_b;
            OP_SUB:  alu_res = operand_a - operand_b;
            OP_SLL:  alu_res = operand_a << shamt;
            OP_XOR:  alu_res = operand_a ^ operand_b;
            OP_OR:   alu_res = operand_a | operand_b;
            OP_AND:  alu_res = operand_a & operand_b;
            OP_SRL:  alu_res = operand_a >> shamt;
            OP_SRA:  alu_res = $unsigned($signed(operand_a) >>> shamt);
            OP_SLT:  alu_res = {{(XLEN-1){1'b0}}, lt_s};
            OP_SLTU: alu_res = {{(XLEN-1){1'b0}}, lt_u};
            default: alu_res = '0;
        endcase
    end

    always_comb begin
        bcond_c = 1'b0;
        if (alu_op == OP_SUB) begin
            case (funct3)
                3'b000:  bcond_c = eq;
                3'b001:  bcond_c = !eq;
                3'b100:  bcond_c = lt_s;
                3'b101:  bcond_c = !lt_s;
                3'b110:  bcond_c = lt_u;
                3'b111:  bcond_c = !lt_u;
                default: bcond_c = 1'b0;
            endcase
        end
    end

`ifdef ALU_MULDIV_EN
    localparam logic [3:0] OP_MUL   = 4'd10;
    localparam logic [3:0] OP_MULHU = 4'd11;
    localparam logic [3:0] OP_DIV   = 4'd12;
    localparam logic [3:0] OP_DIVU  = 4'd13;
    localparam logic [3:0] OP_REM   = 4'd14;

    // acc holds {hi, lo} of the product while multiplying (lo starts as the
    // multiplier and is consumed from bit 0), and {remainder, quotient} while
    // dividing (quotient starts as the dividend and is consumed from the MSB).
    logic [2*XLEN-1:0]  acc;
    logic [2*XLEN-1:0]  acc_next;
    logic [XLEN-1:0]    mdr;        // multiplicand or divisor magnitude
    logic [3:0]         md_op;
    logic [SHAMT_W-1:0] cnt;
    logic               neg_q;
    logic               neg_r;
    logic               div_zero;

    logic               is_md;
    logic               signed_div;
    logic [XLEN-1:0]    a_mag;
    logic [XLEN-1:0]    b_mag;
    logic [XLEN-1:0]    mul_addend;
    logic [XLEN:0]      mul_sum;
    logic [XLEN:0]      div_shift;
    logic [XLEN:0]      div_diff;
    logic [XLEN-1:0]    q_mag;
    logic [XLEN-1:0]    r_mag;
    logic [XLEN-1:0]    md_res;

    // Ops 10..15 are 4'b1010 .. 4'b1111.
    assign is_md      = alu_op[3] && (alu_op[2] || alu_op[1]);
    assign signed_div = (alu_op == OP_DIV) || (alu_op == OP_REM);
    assign a_mag      = (signed_div && operand_a[XLEN-1]) ? -operand_a : operand_a;
    assign b_mag      = (signed_div && operand_b[XLEN-1]) ? -operand_b : operand_b;

    always_comb begin
        mul_addend = acc[0] ? mdr : '0;
        mul_sum    = {1'b0, acc[2*XLEN-1:XLEN]} + {1'b0, mul_addend};
        div_shift  = {acc[2*XLEN-1:XLEN], acc[XLEN-1]};
        // The partial remainder stays below the divisor, so bit XLEN of the
        // difference is set only when the trial subtraction borrows.
        div_diff   = div_shift - {1'b0, mdr};
        if (!md_op[2]) begin
            acc_next = {mul_sum, acc[XLEN-1:1]};
        end else if (!div_diff[XLEN]) begin
            acc_next = {div_diff[XLEN-1:0], acc[XLEN-2:0], 1'b1};
        end else begin
            acc_next = {div_shift[XLEN-1:0], acc[XLEN-2:0], 1'b0};
        end
    end

    assign q_mag = acc_next[XLEN-1:0];
    assign r_mag = acc_next[2*XLEN-1:XLEN];

    // Final result taken from the last step's value. Divide by zero leaves
    // q_mag all ones and r_mag equal to the dividend magnitude, so only the
    // signed quotient needs an override (its sign fix-up would spoil it).
    always_comb begin
        md_res = r_mag;
        case (md_op)
            OP_MUL:   md_res = q_mag;
            OP_MULHU: md_res = r_mag;
            OP_DIV:   md_res = div_zero ? '1 : (neg_q ? -q_mag : q_mag);
            OP_DIVU:  md_res = q_mag;
            OP_REM:   md_res = neg_r ? -r_mag : r_mag;
            default:  md_res = r_mag;
        endcase
    end
`endif

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= ST_IDLE;
            out_valid <= 1'b0;
            result    <= '0;
            bcond     <= 1'b0;
            busy      <= 1'b0;
`ifdef ALU_MULDIV_EN
            acc       <= '0;
            mdr       <= '0;
            md_op     <= OP_ADD;
            cnt       <= '0;
            neg_q     <= 1'b0;
            neg_r     <= 1'b0;
            div_zero  <= 1'b0;
`endif
        end else if (flush) begin
            state     <= ST_IDLE;
            out_valid <= 1'b0;
            busy      <= 1'b0;
        end else begin
            case (state)
`ifdef ALU_MULDIV_EN
                ST_CALC: begin
                    acc <= acc_next;
                    cnt <= cnt - SHAMT_W'(1);
                    if (cnt == '0) begin
                        result    <= md_res;
                        bcond     <= 1'b0;
                        out_valid <= 1'b1;
                        busy      <= 1'b0;
                        state     <= ST_DONE;
                    end
                end
`endif
                ST_DONE: begin
                    if (out_ready && !in_valid) begin
                        out_valid <= 1'b0;
                        state     <= ST_IDLE;
                    end
                end
                default: ;
            endcase

            // Acceptance happens only from IDLE or DONE and overrides the
            // DONE hand-off above (back-to-back issue).
            if (accept) begin
`ifdef ALU_MULDIV_EN
                if (is_md) begin
                    md_op     <= alu_op;
                    cnt       <= SHAMT_W'(XLEN - 1);
                    neg_q     <= (alu_op == OP_DIV) && (operand_a[XLEN-1] ^ operand_b[XLEN-1]);
                    neg_r     <= (alu_op == OP_REM) && operand_a[XLEN-1];
                    div_zero  <= (operand_b == '0);
                    if (alu_op[2]) begin
                        acc <= {{XLEN{1'b0}}, a_mag};
                        mdr <= b_mag;
                    end else begin
                        acc <= {{XLEN{1'b0}}, operand_b};
                        mdr <= operand_a;
                    end
                    out_valid <= 1'b0;
                    busy      <= 1'b1;
                    state     <= ST_CALC;
                end else
`endif
                begin
                    result    <= alu_res;
                    bcond     <= bcond_c;
                    out_valid <= 1'b1;
                    state     <= ST_DONE;
                end
            end
        end
    end

endmodule

// File: tb/tb_alu_muldiv_unit.sv
`timescale 1ns/1ps
module tb_alu_muldiv_unit;

  localparam int XLEN = 32;
  localparam int W    = XLEN + 1;
`ifdef ALU_MULDIV_EN
  localparam bit MD_EN = 1'b1;
`else
  localparam bit MD_EN = 1'b0;
`endif
  localparam int MD_LAT = XLEN + 1;

  localparam logic [3:0] ADD = 4'd0, SUB = 4'd1, SLL = 4'd2, XORO = 4'd3;
  localparam logic [3:0] MUL = 4'd10, MULHU = 4'd11, DIV = 4'd12, DIVU = 4'd13;
  localparam logic [3:0] REM = 4'd14, REMU = 4'd15;

  logic            clk, reset, in_valid, in_ready, flush, out_valid, out_ready, bcond, busy;
  logic [3:0]      alu_op;
  logic [2:0]      funct3;
  logic [XLEN-1:0] operand_a, operand_b, result;
  logic [1:0]      state_dbg;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int ready_mode = 1;   // 0: out_ready low, 1: high, 2: random
  int acc_cyc = 0;
  logic [W-1:0] exp_q[$];
  int           rdy_q[$];

  alu_muldiv_unit #(.XLEN(XLEN)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .alu_op(alu_op), .funct3(funct3), .operand_a(operand_a), .operand_b(operand_b),
    .flush(flush), .out_valid(out_valid), .out_ready(out_ready), .result(result),
    .bcond(bcond), .busy(busy), .state_dbg(state_dbg)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- reference model ----------------
  function automatic logic [W-1:0] model(input logic [3:0] op, input logic [2:0] f3,
                                         input logic [31:0] a, input logic [31:0] b);
    logic [31:0] r;
    logic        bc;
    longint      sa, sb;
    logic [63:0] p;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    p  = {32'd0, a} * {32'd0, b};
    r  = '0;
    bc = 1'b0;
    case (op)
      4'd0: r = a + b;
      4'd1: begin
        r = a - b;
        case (f3)
          3'd0: bc = (a == b);
          3'd1: bc = (a != b);
          3'd4: bc = (sa < sb);
          3'd5: bc = (sa >= sb);
          3'd6: bc = (a < b);
          3'd7: bc = (a >= b);
          default: bc = 1'b0;
        endcase
      end
      4'd2: r = a << b[4:0];
      4'd3: r = a ^ b;
      4'd4: r = a | b;
      4'd5: r = a & b;
      4'd6: r = a >> b[4:0];
      4'd7: r = 32'(sa >>> b[4:0]);
      4'd8: r = (sa < sb) ? 32'd1 : 32'd0;
      4'd9: r = (a < b) ? 32'd1 : 32'd0;
      4'd10: r = p[31:0];
      4'd11: r = p[63:32];
      4'd12: r = (b == 0) ? 32'hFFFF_FFFF : 32'(sa / sb);
      4'd13: r = (b == 0) ? 32'hFFFF_FFFF : a / b;
      4'd14: r = (b == 0) ? a : 32'(sa % sb);
      default: r = (b == 0) ? a : a % b;
    endcase
    if (!MD_EN && op >= 4'd10) r = '0;
    return {bc, r};
  endfunction

  function automatic int lat_of(input logic [3:0] op);
    return (MD_EN && op >= 4'd10) ? MD_LAT : 1;
  endfunction

  function automatic logic [31:0] md(input logic [31:0] v);
    return MD_EN ? v : 32'd0;
  endfunction

  function automatic logic [31:0] rand_val();
    case ($urandom_range(0, 7))
      0: return 32'd0;
      1: return 32'd1;
      2: return 32'hFFFF_FFFF;
      3: return 32'h8000_0000;
      4: return 32'h7FFF_FFFF;
      5: return $urandom_range(0, 40);
      default: return $urandom();
    endcase
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [3:0] op, input logic [2:0] f3,
                      input logic [31:0] a, input logic [31:0] b);
    int n;
    alu_op = op; funct3 = f3; operand_a = a; operand_b = b; in_valid = 1'b1;
    n = 0;
    @(negedge clk);
    while (!in_ready && n < 400) begin
      n++;
      @(negedge clk);
    end
    check("send_accept_timeout", in_ready, 1);
    step();
    in_valid = 1'b0;
    acc_cyc  = cyc;
  endtask

  task automatic wait_out(output int n, output int nbusy);
    n = 0;
    nbusy = 0;
    do begin
      @(negedge clk);
      n++;
      if (busy) nbusy++;
    end while (!out_valid && n < 200);
    check("wait_out_timeout", out_valid, 1);
  endtask

  task automatic expect_res(input string name, input logic [31:0] r, input logic b);
    int n, nb;
    wait_out(n, nb);
    check(name, result, r);
    check({name, "_bcond"}, bcond, b);
    step();
  endtask

  // ---------------- out_ready generator ----------------
  initial begin
    out_ready = 1'b0;
    forever begin
      @(posedge clk);
      #2;
      case (ready_mode)
        0: out_ready = 1'b0;
        1: out_ready = 1'b1;
        default: out_ready = ($urandom_range(0, 3) != 0);
      endcase
    end
  end

  // ---------------- scoreboard / compare process ----------------
  initial begin
    logic         have, front_rdy, exp_ir;
    logic [W-1:0] front;
    forever begin
      @(negedge clk);
      if (!reset) begin
        check("rst_out_valid", out_valid, 0);
        check("rst_busy", busy, 0);
        check("rst_result", result, 0);
        check("rst_bcond", bcond, 0);
        check("rst_in_ready", in_ready, 1);
        exp_q.delete();
        rdy_q.delete();
      end else begin
        have      = (exp_q.size() != 0);
        front_rdy = have && (rdy_q[0] <= cyc);
        exp_ir    = !flush && (!have || (front_rdy && out_ready));
        check("out_valid", out_valid, front_rdy);
        check("busy", busy, have && !front_rdy);
        check("in_ready", in_ready, exp_ir);
        if (front_rdy && out_valid) begin
          front = exp_q[0];
          check("result", result, front[XLEN-1:0]);
          check("bcond", bcond, front[XLEN]);
        end
        if (flush) begin
          exp_q.delete();
          rdy_q.delete();
        end else begin
          if (front_rdy && out_ready) begin
            void'(exp_q.pop_front());
            void'(rdy_q.pop_front());
          end
          if (in_valid && exp_ir) begin
            exp_q.push_back(model(alu_op, funct3, operand_a, operand_b));
            rdy_q.push_back(cyc + lat_of(alu_op));
          end
        end
      end
    end
  end

  // ---------------- main sequence ----------------
  initial begin
    int n, nb, t1, t2, t3;
    logic [3:0] op;
    reset = 1'b1; in_valid = 1'b0; flush = 1'b0;
    alu_op = '0; funct3 = '0; operand_a = '0; operand_b = '0;
    #1 reset = 1'b0;
    repeat (3) @(posedge clk);
    #1 reset = 1'b1;
    step();

    // Hand-computed values pinning the model.
    check("pin_blt_ovf", model(SUB, 3'd4, 32'h7FFF_FFFF, 32'h8000_0000), {1'b1, 32'hFFFF_FFFF} & {1'b0, 32'hFFFF_FFFF});
    check("pin_div_neg", model(DIV, 3'd0, 32'hFFFF_FFF9, 32'd2), {1'b0, md(32'hFFFF_FFFD)});
    check("pin_rem_neg", model(REM, 3'd0, 32'hFFFF_FFF9, 32'd2), {1'b0, md(32'hFFFF_FFFF)});
    check("pin_mulhu", model(MULHU, 3'd0, 32'hFFFF_FFFF, 32'd2), {1'b0, md(32'd1)});
    check("pin_sra", model(4'd7, 3'd0, 32'h8000_0000, 32'd36), {1'b0, 32'hF800_0000});

    // Reset in the middle of a divide, then a plain ADD.
    ready_mode = 1;
    send(DIV, 3'd0, 32'd100, 32'd3);
    repeat (9) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    check("midrst_out_valid", out_valid, 0);
    check("midrst_busy", busy, 0);
    check("midrst_result", result, 0);
    check("midrst_in_ready", in_ready, 1);
    step();
    reset = 1'b1;
    step();
    send(ADD, 3'd0, 32'd5, 32'd7);
    expect_res("add_5_7", 32'd12, 1'b0);

    // Branch conditions on an overflowing difference.
    send(SUB, 3'd4, 32'h7FFF_FFFF, 32'h8000_0000);
    expect_res("blt_ovf", 32'hFFFF_FFFF, 1'b0);
    send(SUB, 3'd6, 32'h7FFF_FFFF, 32'h8000_0000);
    expect_res("bltu", 32'hFFFF_FFFF, 1'b1);
    send(SUB, 3'd5, 32'h7FFF_FFFF, 32'h8000_0000);
    expect_res("bge_ovf", 32'hFFFF_FFFF, 1'b1);
    send(SUB, 3'd2, 32'd9, 32'd9);
    expect_res("f3_unlisted", 32'd0, 1'b0);
    send(ADD, 3'd4, 32'h7FFF_FFFF, 32'h8000_0000);
    expect_res("add_nobcond", 32'hFFFF_FFFF, 1'b0);

    // Multiply latency and busy window.
    send(MUL, 3'd0, 32'hFFFF_FFFF, 32'd2);
    wait_out(n, nb);
    check("mul_latency", n, MD_EN ? MD_LAT : 1);
    check("mul_busy_cycles", nb, MD_EN ? XLEN : 0);
    check("mul_result", result, md(32'hFFFF_FFFE));
    step();
    send(MULHU, 3'd0, 32'hFFFF_FFFF, 32'd2);
    expect_res("mulhu", md(32'd1), 1'b0);

    // Divide corner cases.
    send(DIV, 3'd0, 32'd7, 32'd0);                 expect_res("div_by0", md(32'hFFFF_FFFF), 1'b0);
    send(REMU, 3'd0, 32'd7, 32'd0);                expect_res("remu_by0", md(32'd7), 1'b0);
    send(REM, 3'd0, 32'hFFFF_FFF9, 32'd0);         expect_res("rem_by0_neg", md(32'hFFFF_FFF9), 1'b0);
    send(DIV, 3'd0, 32'h8000_0000, 32'hFFFF_FFFF); expect_res("div_ovf", md(32'h8000_0000), 1'b0);
    send(REM, 3'd0, 32'h8000_0000, 32'hFFFF_FFFF); expect_res("rem_ovf", md(32'd0), 1'b0);
    send(DIV, 3'd0, 32'hFFFF_FFF9, 32'd2);         expect_res("div_m7_2", md(32'hFFFF_FFFD), 1'b0);
    send(REM, 3'd0, 32'hFFFF_FFF9, 32'd2);         expect_res("rem_m7_2", md(32'hFFFF_FFFF), 1'b0);
    send(DIVU, 3'd0, 32'hFFFF_FFF9, 32'd2);        expect_res("divu_big", md(32'h7FFF_FFFC), 1'b0);

    // Back-to-back issue, then back-pressure.
    send(ADD, 3'd0, 32'h10, 32'h20);
    t1 = acc_cyc;
    send(XORO, 3'd0, 32'hF0F0, 32'h0FF0);
    t2 = acc_cyc;
    send(SLL, 3'd0, 32'd3, 32'd33);
    t3 = acc_cyc;
    ready_mode = 0;
    check("b2b_gap1", t2 - t1, 1);
    check("b2b_gap2", t3 - t2, 1);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("hold_out_valid", out_valid, 1);
      check("hold_result", result, 32'd6);
      check("hold_in_ready", in_ready, 0);
      step();
    end
    ready_mode = 1;
    step();
    step();

    // Flush during a long operation, with a competing request.
    ready_mode = 0;
    step();
    send(DIVU, 3'd0, 32'd1000, 32'd7);
    repeat (4) @(posedge clk);
    #1;
    flush = 1'b1; in_valid = 1'b1; alu_op = ADD; operand_a = 32'd1; operand_b = 32'd2;
    @(negedge clk);
    check("flush_in_ready", in_ready, 0);
    step();
    flush = 1'b0; in_valid = 1'b0;
    @(negedge clk);
    check("flush_state_idle", state_dbg, 0);
    check("flush_out_valid", out_valid, 0);
    check("flush_busy", busy, 0);
    step();

    // Randomized traffic.
    ready_mode = 2;
    for (int k = 0; k < 200; k++) begin
      op = 4'($urandom_range(0, 15));
      if (MD_EN && op >= 4'd10 && $urandom_range(0, 2) != 0) op = 4'($urandom_range(0, 9));
      send(op, 3'($urandom_range(0, 7)), rand_val(), rand_val());
      if ($urandom_range(0, 11) == 0) begin
        repeat ($urandom_range(0, 6)) step();
        flush = 1'b1;
        in_valid = 1'($urandom_range(0, 1));
        step();
        flush = 1'b0;
        in_valid = 1'b0;
      end else if ($urandom_range(0, 5) == 0) begin
        repeat ($urandom_range(1, 3)) step();
      end
    end

    // Drain.
    ready_mode = 1;
    n = 0;
    while (exp_q.size() != 0 && n < 200) begin
      step();
      n++;
    end
    check("drain_empty", exp_q.size(), 0);
    step();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
